control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: Control

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 in_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 in_rst  input  1  synchronous, active-high reset.
REQ-005 in_opcode  input  4  instruction opcode.
REQ-006 out_ctrl_regwrt  output  1  register-file write enable.
REQ-007 out_ctrl_memrd  output  1  data-memory read enable.
REQ-008 out_ctrl_memwrt  output  1  data-memory write enable.
REQ-009 out_ctrl_alusrc  output  1  ALU B operand: 0=register, 1=immediate.
REQ-010 out_ctrl_aluop  output  3  ALU operation: 000 pass-B/none, 001 add, 010 sub, 011 negate, 100 pass-A.
REQ-011 out_ctrl_memtoreg  output  1  write-back source: 0=ALU, 1=memory.
REQ-012 out_ctrl_branch  output  1  conditional branch.
REQ-013 out_ctrl_btype  output  1  branch condition: 0=zero (BRZ), 1=negative (BRN).
REQ-014 out_ctrl_jump  output  1  unconditional jump.

Function
REQ-015 All outputs SHALL be registered, updating on the rising in_clk edge from the in_opcode sampled at that edge; latency is 1 cycle, with no handshake.
REQ-016 The opcodes SHALL decode as follows; each line lists the outputs driven to 1 and the aluop value, and every output not listed SHALL be 0:
  - 0000 NOP: none; aluop 000.
  - 1111 SVPC: regwrt, alusrc; aluop 001.
  - 1110 LD: regwrt, memrd, memtoreg; aluop 100.
  - 0011 ST: memwrt; aluop 100.
  - 0100 ADD: regwrt; aluop 001.
  - 0101 INC: regwrt, alusrc; aluop 001.
  - 0110 NEG: regwrt; aluop 011.
  - 0111 SUB: regwrt; aluop 010.
  - 1000 J: jump; aluop 000.
  - 1001 BRZ: branch, btype=0; aluop 000.
  - 1010 JM: jump, memrd; aluop 100.
  - 1011 BRN: branch, btype=1; aluop 000.
REQ-017 Unused opcodes 0001, 0010, 1100 and 1101 SHALL decode exactly as NOP.
REQ-018 memrd and memwrt SHALL never both be 1; branch and jump SHALL never both be 1.
REQ-019 btype SHALL be 0 whenever branch is 0.
REQ-020 The decode SHALL be a pure function of the sampled opcode, with no history; back-to-back opcode changes SHALL each appear one cycle later.

Reset
REQ-021 When in_rst=1 at a rising edge, every output SHALL become 0 (NOP pattern), regardless of in_opcode.
REQ-022 Reset SHALL take priority over decode in the same cycle; the first post-reset edge SHALL present the decode of the then-current opcode.

Configuration
REQ-023 With CONTROL_ILLEGAL_DETECT_EN defined, the block SHALL add a registered 1-bit output out_ctrl_illegal:
  - 1 for opcodes 0001, 0010, 1100 and 1101, otherwise 0.
  - Reset value 0; same 1-cycle latency as the other outputs.
  - All other outputs unchanged.
REQ-024 Without CONTROL_ILLEGAL_DETECT_EN, out_ctrl_illegal SHALL not exist, and the behaviour SHALL be otherwise identical.

Verification
REQ-025 Reset: in_rst=1 with in_opcode=1110, one edge -> all outputs 0.
REQ-026 Sweep: opcode 0..15 held one cycle each -> each output pattern matches REQ-016/REQ-017 exactly one cycle after its opcode is applied.
REQ-027 Loads/stores: LD 1110 -> regwrt=1, memrd=1, memtoreg=1, aluop=100; ST 0011 -> memwrt=1, all others 0 except aluop=100.
REQ-028 Branches: BRZ 1001 -> branch=1, btype=0; BRN 1011 -> branch=1, btype=1; J 1000 -> jump=1, branch=0.
REQ-029 Mid-stream reset: ADD 0100 decoded, then in_rst=1 for one edge -> outputs 0; the next edge with 0100 still applied -> regwrt=1, aluop=001.
REQ-030 With CONTROL_ILLEGAL_DETECT_EN: opcode 1100 -> out_ctrl_illegal=1 and all other outputs 0; opcode 0000 -> out_ctrl_illegal=0.

Source files
------------

// File: rtl/control_unit.sv
// control_unit: registered opcode-to-control decoder, 1-cycle latency; CONTROL_ILLEGAL_DETECT_EN adds out_ctrl_illegal
module control_unit (
  input  logic       in_clk,
  input  logic       in_rst,
  input  logic [3:0] in_opcode,
  output logic       out_ctrl_regwrt,
  output logic       out_ctrl_memrd,
  output logic       out_ctrl_memwrt,
  output logic       out_ctrl_alusrc,
  output logic [2:0] out_ctrl_aluop,
  output logic       out_ctrl_memtoreg,
  output logic       out_ctrl_branch,
  output logic       out_ctrl_btype,
  output logic       out_ctrl_jump
`ifdef CONTROL_ILLEGAL_DETECT_EN
  ,
  output logic       out_ctrl_illegal
`endif
);
  // {regwrt, memrd, memwrt, alusrc, aluop[2:0], memtoreg, branch, btype, jump}
  logic [10:0] w_ctrl;
  logic [10:0] r_ctrl;
  always_comb begin
    case (in_opcode)
      4'b1111: w_ctrl = 11'b1001_001_0000;
      4'b1110: w_ctrl = 11'b1100_100_1000;
      4'b0011: w_ctrl = 11'b0010_100_0000;
      4'b0100: w_ctrl = 11'b1000_001_0000;
      4'b0101: w_ctrl = 11'b1001_001_0000;
      4'b0110: w_ctrl = 11'b1000_011_0000;
      4'b0111: w_ctrl = 11'b1000_010_0000;
      4'b1000: w_ctrl = 11'b0000_000_0001;
      4'b1001: w_ctrl = 11'b0000_000_0100;
      4'b1010: w_ctrl = 11'b0100_100_0001;
      4'b1011: w_ctrl = 11'b0000_000_0110;
      default: w_ctrl = '0;
    endcase
  end
  always_ff @(posedge in_clk) r_ctrl <= in_rst ? '0 : w_ctrl;
  assign {out_ctrl_regwrt, out_ctrl_memrd, out_ctrl_memwrt, out_ctrl_alusrc, out_ctrl_aluop,
          out_ctrl_memtoreg, out_ctrl_branch, out_ctrl_btype, out_ctrl_jump} = r_ctrl;
`ifdef CONTROL_ILLEGAL_DETECT_EN
  logic w_illegal;
  logic r_illegal;
  assign w_illegal = in_opcode inside {4'b0001, 4'b0010, 4'b1100, 4'b1101};
  always_ff @(posedge in_clk) r_illegal <= in_rst ? 1'b0 : w_illegal;
  assign out_ctrl_illegal = r_illegal;
`endif
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: scoreboard bench; stimulus queues hand-computed expectations, monitor compares one cycle later
module tb_control_unit;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] opcode = 4'b1110;
  logic       regwrt, memrd, memwrt, alusrc, memtoreg, branch, btype, jump;
  logic [2:0] aluop;
  logic       illegal;
  int         n_checks = 0;
  int         n_errors = 0;

  typedef struct {
    logic [11:0] exp;
    string       name;
  } item_t;
  item_t sb[$];

  always #5 clk = ~clk;

  control_unit dut (
    .in_clk(clk), .in_rst(rst), .in_opcode(opcode),
    .out_ctrl_regwrt(regwrt), .out_ctrl_memrd(memrd), .out_ctrl_memwrt(memwrt),
    .out_ctrl_alusrc(alusrc), .out_ctrl_aluop(aluop), .out_ctrl_memtoreg(memtoreg),
    .out_ctrl_branch(branch), .out_ctrl_btype(btype), .out_ctrl_jump(jump)
`ifdef CONTROL_ILLEGAL_DETECT_EN
    , .out_ctrl_illegal(illegal)
`endif
  );
`ifndef CONTROL_ILLEGAL_DETECT_EN
  assign illegal = 1'b0;
`endif

  // Hand-written decode table: {regwrt,memrd,memwrt,alusrc,aluop,memtoreg,branch,btype,jump,illegal}
  function automatic logic [11:0] expect_of(input logic r, input logic [3:0] op);
    logic [11:0] e;
    if (r) return 12'b0;
    case (op)
      4'd15: e = 12'b1001_001_0000_0;
      4'd14: e = 12'b1100_100_1000_0;
      4'd3:  e = 12'b0010_100_0000_0;
      4'd4:  e = 12'b1000_001_0000_0;
      4'd5:  e = 12'b1001_001_0000_0;
      4'd6:  e = 12'b1000_011_0000_0;
      4'd7:  e = 12'b1000_010_0000_0;
      4'd8:  e = 12'b0000_000_0001_0;
      4'd9:  e = 12'b0000_000_0100_0;
      4'd10: e = 12'b0100_100_0001_0;
      4'd11: e = 12'b0000_000_0110_0;
`ifdef CONTROL_ILLEGAL_DETECT_EN
      4'd1, 4'd2, 4'd12, 4'd13: e = 12'b0000_000_0000_1;
`endif
      default: e = 12'b0;
    endcase
    return e;
  endfunction

  task automatic issue(input logic r, input logic [3:0] op, input string name);
    item_t it;
    @(negedge clk);
    rst = r;
    opcode = op;
    it.exp = expect_of(r, op);
    it.name = $sformatf("%s(rst=%0b,op=%04b)", name, r, op);
    sb.push_back(it);
  endtask

  initial begin : monitor
    item_t it;
    logic [11:0] act;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        it = sb.pop_front();
        act = {regwrt, memrd, memwrt, alusrc, aluop, memtoreg, branch, btype, jump, illegal};
        n_checks++;
        if (act !== it.exp) begin
          n_errors++;
          $display("FAIL %s: got %012b expected %012b", it.name, act, it.exp);
        end
        n_checks++;
        if ((memrd && memwrt) || (branch && jump) || (btype && !branch)) begin
          n_errors++;
          $display("FAIL exclusivity %s: got %012b", it.name, act);
        end
      end
    end
  end

  initial begin : stimulus
    int budget;
    issue(1'b1, 4'b1110, "reset_ld");
    issue(1'b1, 4'b1110, "reset_hold");
    for (int i = 0; i < 16; i++) issue(1'b0, 4'(i), "sweep");
    issue(1'b0, 4'b1110, "ld");
    issue(1'b0, 4'b0011, "st");
    issue(1'b0, 4'b1001, "brz");
    issue(1'b0, 4'b1011, "brn");
    issue(1'b0, 4'b1000, "j");
    issue(1'b0, 4'b1010, "jm");
    issue(1'b0, 4'b0100, "add");
    issue(1'b1, 4'b0100, "midreset");
    issue(1'b0, 4'b0100, "add_after_reset");
    issue(1'b0, 4'b1100, "unused_1100");
    issue(1'b0, 4'b0000, "nop");
    issue(1'b0, 4'b1101, "unused_1101");
    issue(1'b0, 4'b0111, "sub");
    budget = 20;
    while (sb.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #2;
    if (sb.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
